// File: rtl/slice_pkg.sv
// Types and helpers shared by the slice serializer and its deserializer counterpart.
package slice_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_e;

    function automatic int ceil_div(input int a, input int b);
        return (a + b - 1) / b;
    endfunction

endpackage

// File: rtl/slice_pick.sv
// Selects SPAN bits of a word starting at a declared index; bits past HI read as zero.
module slice_pick #(
    parameter int HI   = 3,
    parameter int LO   = 0,
    parameter int SPAN = 1,
    parameter int SWAP = 0
) (
    input  logic [(SWAP ? LO : HI):(SWAP ? HI : LO)] word,
    input  logic [31:0]                              index,
    output logic [SPAN-1:0]                          slice
);

    localparam int W = HI - LO + 1;

    // Re-pack by declared index so the word's direction no longer matters.
    logic [W-1:0] flat;

    for (genvar p = LO; p <= HI; p++) begin : g_flat
        assign flat[p-LO] = word[p];
    end

    // The right shift zero-fills, which gives the partial final slice for free.
    assign slice = SPAN'(flat >> (index - 32'(LO)));

endmodule

// File: rtl/slice_serializer.sv
// Captures one word and streams it out SPAN bits per beat, lowest declared index first.
module slice_serializer
    import slice_pkg::*;
#(
    parameter int HI   = 3,
    parameter int LO   = 0,
    parameter int SPAN = 1,
    parameter int SWAP = 0
) (
    input  logic                                     clk,
    input  logic                                     rst,
    input  logic                                     in_valid,
    output logic                                     in_ready,
    input  logic [(SWAP ? LO : HI):(SWAP ? HI : LO)] in_data,
    output logic                                     out_valid,
    input  logic                                     out_ready,
    output logic [SPAN-1:0]                          out_data,
    output logic                                     out_last,
    output logic [31:0]                              out_idx
);

    localparam int W = HI - LO + 1;
    localparam int N = ceil_div(W, SPAN);

    localparam logic [31:0] LO_U     = 32'(LO);
    localparam logic [31:0] HI_U     = 32'(HI);
    localparam logic [31:0] SPAN_U   = 32'(SPAN);
    localparam logic [31:0] IDX_LAST = 32'(LO + (N - 1) * SPAN);

    state_e state_q, state_d;
    logic [(SWAP ? LO : HI):(SWAP ? HI : LO)] word_q, word_d;
    logic [31:0] idx_q, idx_d;
    logic [SPAN-1:0] pick;
    logic last_hit;

    slice_pick #(
        .HI  (HI),
        .LO  (LO),
        .SPAN(SPAN),
        .SWAP(SWAP)
    ) u_pick (
        .word (word_q),
        .index(idx_q),
        .slice(pick)
    );

    assign last_hit = (idx_q + SPAN_U) > HI_U;

    always_comb begin
        state_d   = state_q;
        word_d    = word_q;
        idx_d     = idx_q;
        in_ready  = (state_q == IDLE);
        out_valid = (state_q == SEND);
        out_last  = (state_q == SEND) && last_hit;
        out_data  = (state_q == SEND) ? pick : '0;
        out_idx   = idx_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    word_d  = in_data;
                    idx_d   = LO_U;
                    state_d = SEND;
                end
            end
            SEND: begin
                // No re-accept on the final beat: IDLE always costs one cycle.
                if (out_ready) begin
                    if (last_hit) begin
                        idx_d   = LO_U;
                        state_d = IDLE;
                    end else begin
                        idx_d = idx_q + SPAN_U;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            word_q  <= '0;
            idx_q   <= LO_U;
        end else begin
            state_q <= state_d;
            word_q  <= word_d;
            idx_q   <= idx_d;
        end
    end

    a_hold_stable: assert property (@(posedge clk) disable iff (rst)
        (out_valid && !out_ready) |=> ($stable(out_data) && $stable(out_idx) && $stable(out_last)));

    a_idx_range: assert property (@(posedge clk) disable iff (rst) out_idx <= HI_U);

    a_last_idx: assert property (@(posedge clk) disable iff (rst) out_last |-> out_idx == IDX_LAST);

endmodule

// File: tb/tb_slice_serializer.sv
// Directed checks on fixed configurations plus an exhaustive sweep of every small configuration.
module tb_slice_serializer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, in_valid, out_ready;
    logic [3:0] in_data;
    logic       sweep_go = 1'b0;
    int         sw_done  = 0;
    int         tests    = 0;
    int         fails    = 0;

    logic a_ir, a_ov, a_ol, b_ir, b_ov, b_ol, c_ir, c_ov, c_ol, d_ir, d_ov, d_ol, e_ir, e_ov, e_ol;
    logic [0:0]  a_od, b_od, e_od;
    logic [2:0]  c_od;
    logic [1:0]  d_od;
    logic [31:0] a_oi, b_oi, c_oi, d_oi, e_oi;

    slice_serializer #(.HI(3), .LO(0), .SPAN(1), .SWAP(0)) u_a (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(a_ir), .in_data(in_data),
        .out_valid(a_ov), .out_ready(out_ready), .out_data(a_od), .out_last(a_ol), .out_idx(a_oi));
    slice_serializer #(.HI(3), .LO(0), .SPAN(1), .SWAP(1)) u_b (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(b_ir), .in_data(in_data),
        .out_valid(b_ov), .out_ready(out_ready), .out_data(b_od), .out_last(b_ol), .out_idx(b_oi));
    slice_serializer #(.HI(3), .LO(0), .SPAN(3), .SWAP(0)) u_c (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(c_ir), .in_data(in_data),
        .out_valid(c_ov), .out_ready(out_ready), .out_data(c_od), .out_last(c_ol), .out_idx(c_oi));
    slice_serializer #(.HI(2), .LO(1), .SPAN(2), .SWAP(0)) u_d (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(d_ir), .in_data(in_data[2:1]),
        .out_valid(d_ov), .out_ready(out_ready), .out_data(d_od), .out_last(d_ol), .out_idx(d_oi));
    slice_serializer #(.HI(0), .LO(0), .SPAN(1), .SWAP(0)) u_e (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(e_ir), .in_data(in_data[0:0]),
        .out_valid(e_ov), .out_ready(out_ready), .out_data(e_od), .out_last(e_ol), .out_idx(e_oi));

    // One instance per (HI<3, LO<=HI, SPAN, SWAP); each walks every data value against a bit model.
    for (genvar h = 0; h < 3; h++) begin : g_h
        for (genvar l = 0; l <= h; l++) begin : g_l
            for (genvar s = 1; s <= h - l + 1; s++) begin : g_s
                for (genvar w = 0; w < 2; w++) begin : g_w
                    localparam int W = h - l + 1;
                    localparam int N = (W + s - 1) / s;
                    logic          iv, ird, ov, ord, ol;
                    logic [W-1:0]  dat;
                    logic [s-1:0]  od;
                    logic [31:0]   oi;

                    slice_serializer #(.HI(h), .LO(l), .SPAN(s), .SWAP(w)) u_dut (
                        .clk(clk), .rst(rst), .in_valid(iv), .in_ready(ird), .in_data(dat),
                        .out_valid(ov), .out_ready(ord), .out_data(od), .out_last(ol), .out_idx(oi));

                    initial begin
                        iv  = 1'b0;
                        ord = 1'b1;
                        dat = '0;
                        wait (sweep_go);
                        for (int d = 0; d < (1 << W); d++) begin
                            @(negedge clk);
                            iv  = 1'b1;
                            dat = W'(d);
                            @(negedge clk);
                            iv = 1'b0;
                            for (int b = 0; b < N; b++) begin
                                logic [s-1:0] e;
                                e = '0;
                                for (int k = 0; k < s; k++) begin
                                    int p;
                                    p = l + b * s + k;
                                    // Literal's leftmost bit is HI when descending, LO when ascending.
                                    if (p <= h) e[k] = (w != 0) ? dat[W-1-(p-l)] : dat[p-l];
                                end
                                tests++;
                                if ({ov, od, oi, ol} !== {1'b1, e, 32'(l + b * s), b == N - 1}) begin
                                    fails++;
                                    $display("FAIL sweep h%0d l%0d s%0d w%0d d%0d beat%0d: got %h want %h",
                                             h, l, s, w, d, b, {ov, od, oi, ol},
                                             {1'b1, e, 32'(l + b * s), b == N - 1});
                                end
                                @(negedge clk);
                            end
                            tests++;
                            if ({ird, ov} !== 2'b10) begin
                                fails++;
                                $display("FAIL sweep_idle h%0d l%0d s%0d w%0d d%0d: got %b want 10",
                                         h, l, s, w, d, {ird, ov});
                            end
                        end
                        sw_done++;
                    end
                end
            end
        end
    end

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
        #3;
        tests++;
        if ({a_ir, a_ov, a_ol, a_od, a_oi} !== {3'b100, 1'b0, 32'd0}) begin
            fails++; $display("FAIL reset_a: got %h want %h", {a_ir, a_ov, a_ol, a_od, a_oi}, {3'b100, 1'b0, 32'd0});
        end
        tests++;
        if ({d_ir, d_ov, d_ol, d_od, d_oi} !== {3'b100, 2'b00, 32'd1}) begin
            fails++; $display("FAIL reset_d: got %h want %h", {d_ir, d_ov, d_ol, d_od, d_oi}, {3'b100, 2'b00, 32'd1});
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        tests++;
        if ({a_ir, a_ov} !== 2'b10) begin
            fails++; $display("FAIL post_reset_ready: got %b want 10", {a_ir, a_ov});
        end
    endtask

    task automatic test_serial(input logic swap_sel);
        logic [3:0] seq;
        seq = swap_sel ? 4'b1100 : 4'b0011;   // seq[k] = expected bit on beat k
        @(negedge clk);
        in_valid = 1'b1; in_data = 4'b0011; out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            tests++;
            if (!swap_sel && {a_ov, a_od, a_oi, a_ol} !== {1'b1, seq[k], 32'(k), k == 3}) begin
                fails++; $display("FAIL serial_lsb beat%0d: got %h want %h", k, {a_ov, a_od, a_oi, a_ol}, {1'b1, seq[k], 32'(k), k == 3});
            end
            if (swap_sel && {b_ov, b_od, b_oi, b_ol} !== {1'b1, seq[k], 32'(k), k == 3}) begin
                fails++; $display("FAIL serial_swap beat%0d: got %h want %h", k, {b_ov, b_od, b_oi, b_ol}, {1'b1, seq[k], 32'(k), k == 3});
            end
            @(negedge clk);
        end
        tests++;
        if ({a_ir, a_ov, b_ir, b_ov} !== 4'b1010) begin
            fails++; $display("FAIL serial_done: got %b want 1010", {a_ir, a_ov, b_ir, b_ov});
        end
    endtask

    task automatic test_span3();
        @(negedge clk);
        in_valid = 1'b1; in_data = 4'b1110;
        @(negedge clk);
        in_valid = 1'b0;
        tests++;
        if ({c_ov, c_od, c_oi, c_ol} !== {1'b1, 3'b110, 32'd0, 1'b0}) begin
            fails++; $display("FAIL span3_beat0: got %h want %h", {c_ov, c_od, c_oi, c_ol}, {1'b1, 3'b110, 32'd0, 1'b0});
        end
        @(negedge clk);
        tests++;
        if ({c_ov, c_od, c_oi, c_ol} !== {1'b1, 3'b001, 32'd3, 1'b1}) begin
            fails++; $display("FAIL span3_beat1: got %h want %h", {c_ov, c_od, c_oi, c_ol}, {1'b1, 3'b001, 32'd3, 1'b1});
        end
        @(negedge clk);
        tests++;
        if ({c_ir, c_ov} !== 2'b10) begin
            fails++; $display("FAIL span3_done: got %b want 10", {c_ir, c_ov});
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic test_single_beat();
        @(negedge clk);
        in_valid = 1'b1; in_data = 4'b0101;
        @(negedge clk);
        in_valid = 1'b0;
        tests++;
        if ({d_ov, d_od, d_oi, d_ol} !== {1'b1, 2'b10, 32'd1, 1'b1}) begin
            fails++; $display("FAIL single_d: got %h want %h", {d_ov, d_od, d_oi, d_ol}, {1'b1, 2'b10, 32'd1, 1'b1});
        end
        tests++;
        if ({e_ov, e_od, e_oi, e_ol} !== {1'b1, 1'b1, 32'd0, 1'b1}) begin
            fails++; $display("FAIL single_e: got %h want %h", {e_ov, e_od, e_oi, e_ol}, {1'b1, 1'b1, 32'd0, 1'b1});
        end
        @(negedge clk);
        tests++;
        if ({d_ir, d_ov, e_ir, e_ov} !== 4'b1010) begin
            fails++; $display("FAIL single_done: got %b want 1010", {d_ir, d_ov, e_ir, e_ov});
        end
        repeat (4) @(negedge clk);
    endtask

    task automatic test_stall_reset();
        logic [3:0] seq;
        @(negedge clk);
        in_valid = 1'b1; in_data = 4'b0110; out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            tests++;
            if ({a_ov, a_od, a_oi, a_ol} !== {1'b1, 1'b1, 32'd1, 1'b0}) begin
                fails++; $display("FAIL stall_hold cyc%0d: got %h want %h", i, {a_ov, a_od, a_oi, a_ol}, {1'b1, 1'b1, 32'd1, 1'b0});
            end
        end
        #2 rst = 1'b1;
        #1;
        tests++;
        if ({a_ov, a_ir, a_oi, a_od, a_ol} !== {2'b01, 32'd0, 2'b00}) begin
            fails++; $display("FAIL async_reset: got %h want %h", {a_ov, a_ir, a_oi, a_od, a_ol}, {2'b01, 32'd0, 2'b00});
        end
        @(negedge clk);
        rst = 1'b0; out_ready = 1'b1;
        repeat (2) begin
            @(negedge clk);
            tests++;
            if ({a_ov, a_ir} !== 2'b01) begin
                fails++; $display("FAIL abandon: got %b want 01", {a_ov, a_ir});
            end
        end
        in_valid = 1'b1; in_data = 4'b1000;
        seq = 4'b1000;
        @(negedge clk);
        in_valid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            tests++;
            if ({a_ov, a_od, a_oi, a_ol} !== {1'b1, seq[k], 32'(k), k == 3}) begin
                fails++; $display("FAIL new_word beat%0d: got %h want %h", k, {a_ov, a_od, a_oi, a_ol}, {1'b1, seq[k], 32'(k), k == 3});
            end
            @(negedge clk);
        end
    endtask

    task automatic test_back_to_back();
        logic [3:0] wa, wb;
        wa = 4'b1001; wb = 4'b0110;
        @(negedge clk);
        in_valid = 1'b1; in_data = wa; out_ready = 1'b1;
        @(negedge clk);
        in_data = wb;   // must not disturb the word already captured
        for (int k = 0; k < 4; k++) begin
            tests++;
            if ({a_ir, a_ov, a_od, a_oi} !== {2'b01, wa[k], 32'(k)}) begin
                fails++; $display("FAIL b2b_a beat%0d: got %h want %h", k, {a_ir, a_ov, a_od, a_oi}, {2'b01, wa[k], 32'(k)});
            end
            @(negedge clk);
        end
        tests++;
        if ({a_ir, a_ov} !== 2'b10) begin
            fails++; $display("FAIL b2b_gap: got %b want 10", {a_ir, a_ov});
        end
        @(negedge clk);
        in_valid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            tests++;
            if ({a_ov, a_od, a_oi, a_ol} !== {1'b1, wb[k], 32'(k), k == 3}) begin
                fails++; $display("FAIL b2b_b beat%0d: got %h want %h", k, {a_ov, a_od, a_oi, a_ol}, {1'b1, wb[k], 32'(k), k == 3});
            end
            @(negedge clk);
        end
    endtask

    task automatic test_sweep();
        sweep_go = 1'b1;
        for (int c = 0; c < 5000 && sw_done < 20; c++) @(negedge clk);
        tests++;
        if (sw_done !== 20) begin
            fails++; $display("FAIL sweep_timeout: got %0d configs done want 20", sw_done);
        end
    endtask

    initial begin
        test_reset();
        test_serial(1'b0);
        test_serial(1'b1);
        test_span3();
        test_single_beat();
        test_stall_reset();
        test_back_to_back();
        test_sweep();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/slice_serializer.md
SLICE_SERIALIZER -- requirements
Module: slice_serializer

Interface
REQ-001 Parameter HI, default 3: upper index of the captured word range.
REQ-002 Parameter LO, default 0: lower index of the captured word range; LO <= HI, both >= 0.
REQ-003 Parameter SPAN, default 1: bits emitted per beat; 1 <= SPAN <= HI-LO+1.
REQ-004 Parameter SWAP, default 0: 0 declares the word as [HI:LO] (descending); 1 declares it as [LO:HI] (ascending).
REQ-005 Derived localparams: W = HI-LO+1; N = ceil(W/SPAN) beats per word.
REQ-006 clk  input  1  sole clock; all state updates on the rising edge.
REQ-007 rst  input  1  reset, asynchronous and active-high.
REQ-008 in_valid  input  1  word offered.
REQ-009 in_ready  output  1  word accepted when in_valid && in_ready at a rising edge.
REQ-010 in_data  input  W  word, declared range per SWAP.
REQ-011 out_valid  output  1  slice present.
REQ-012 out_ready  input  1  slice consumed when out_valid && out_ready at a rising edge.
REQ-013 out_data  output  SPAN  current slice.
REQ-014 out_last  output  1  current slice is the final beat (beat N-1) of the word.
REQ-015 out_idx  output  32  word index of out_data[0] (LO + k*SPAN for beat k).

Function
REQ-016 The FSM SHALL have two states: IDLE (in_ready=1, out_valid=0) and SEND (in_ready=0, out_valid=1).
REQ-017 In IDLE, an accepted word SHALL be captured into a W-bit register, out_idx set to LO, and the FSM SHALL move to SEND; out_valid rises the following cycle.
REQ-018 In SEND, out_data[k] SHALL equal the captured bit at declared index out_idx+k for k = 0..SPAN-1, independent of SWAP.
REQ-019 Bits whose index exceeds HI SHALL read as 0 (zero-fill of the final partial slice).
REQ-020 In SEND without out_ready, out_data, out_idx and out_last SHALL hold stable.
REQ-021 On a consumed non-final beat, out_idx SHALL advance by SPAN.
REQ-022 On a consumed final beat, the FSM SHALL return to IDLE; there is no same-cycle re-accept, so throughput is N+1 cycles per word.
REQ-023 out_last SHALL be 1 exactly when out_idx + SPAN > HI, so that out_last=1 on the first beat when N=1.
REQ-024 in_data SHALL be ignored outside IDLE; the captured word is never modified mid-transfer.
REQ-025 Index arithmetic SHALL be 32-bit unsigned, and out_idx SHALL never exceed HI.

Reset
REQ-026 When rst is asserted, the FSM SHALL go to IDLE, out_valid=0, out_last=0, out_idx=LO, out_data=0 and the captured word SHALL be 0, immediately and without waiting for clk.
REQ-027 Reset asserted mid-SEND SHALL abandon the word; the first beat after deassertion comes only from a newly accepted word.
REQ-028 in_ready SHALL be 1 during and immediately after reset.

Structure
REQ-029 The state enum (IDLE, SEND) SHALL live in the shared package slice_pkg; W and N remain local derived parameters.
REQ-030 One sub-module slice_pick (combinational, parameters HI/LO/SPAN/SWAP, inputs word and index, output zero-filled slice) SHALL implement REQ-018/REQ-019, so that the deserializer counterpart can reuse it.
REQ-031 Concurrent assertions in the block SHALL check REQ-020 and REQ-025.

Verification
REQ-032 HI=3, LO=0, SPAN=1, SWAP=0, in_data=4'b0011, out_ready=1 -> out_data 1,1,0,0; out_idx 0,1,2,3; out_last only on beat 4; in_ready back high on the cycle after beat 4.
REQ-033 Same as REQ-032 but SWAP=1 -> out_data 0,0,1,1 (index 0 is the MSB of the literal).
REQ-034 HI=3, LO=0, SPAN=3, SWAP=0, in_data=4'b1110 -> beats 3'b110 (idx 0), then 3'b001 (idx 3, zero-filled, last).
REQ-035 HI=2, LO=1, SPAN=2, in_data=2'b10 -> single beat out_data=2'b10, out_idx=1, out_last=1; HI=LO=0 -> single 1-bit beat.
REQ-036 Hold out_ready=0 for 5 cycles on beat 2 -> outputs stable; then rst pulsed asynchronously mid-SEND -> out_valid=0 before the next edge, in_ready=1.
REQ-037 The bench SHALL sweep all HI<3, LO<=HI, SPAN, SWAP and all data values, and compare the beat stream against a reference model.
